// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : RV32I instruction-fetch stage. Holds the PC, a word-addressed
//            instruction memory with a program-load port, and the IF/ID register.
// Revision : 1.0
// ============================================================================
module if_stage #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    INST_MEM_DEPTH = 1024,
    parameter logic [DATA_WIDTH-1:0] RESET_PC       = 32'h0000_0000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              stall_i,
    input  logic                              redirect_i,
    input  logic [DATA_WIDTH-1:0]             redirect_pc_i,
    input  logic                              imem_we_i,
    input  logic [$clog2(INST_MEM_DEPTH)-1:0] imem_waddr_i,
    input  logic [DATA_WIDTH-1:0]             imem_wdata_i,
    output logic [DATA_WIDTH-1:0]             pc_o,
    output logic                              if_id_valid_o,
    output logic [DATA_WIDTH-1:0]             if_id_pc_o,
    output logic [DATA_WIDTH-1:0]             if_id_pc4_o,
    output logic [DATA_WIDTH-1:0]             if_id_instr_o
);

    localparam int                    INST_MEM_ADDR_WIDTH = $clog2(INST_MEM_DEPTH);
    localparam logic [DATA_WIDTH-1:0] c_NOP_INSTR         = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0] r_mem [INST_MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_id_pc;
    logic [DATA_WIDTH-1:0] r_id_pc4;
    logic [DATA_WIDTH-1:0] r_id_instr;

    logic [DATA_WIDTH-1:0] w_fetch;
    logic [DATA_WIDTH-1:0] w_pc4;
    logic [DATA_WIDTH-1:0] w_redirect_pc;
    logic                  w_unused_redirect_lsbs;

    // Upper PC bits are dropped, so fetches wrap modulo the memory size.
    assign w_fetch       = r_mem[r_pc[INST_MEM_ADDR_WIDTH+1:2]];
    assign w_pc4         = r_pc + DATA_WIDTH'(4);
    assign w_redirect_pc = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
    assign w_unused_redirect_lsbs = &{1'b0, redirect_pc_i[1:0]};

    // Program-load port; a same-cycle fetch of this word still sees the old data.
    always_ff @(posedge clk) begin
        if (imem_we_i) begin
            r_mem[imem_waddr_i] <= imem_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_id_pc    <= '0;
            r_id_pc4   <= '0;
            r_id_instr <= c_NOP_INSTR;
        end else if (redirect_i) begin
            r_pc       <= w_redirect_pc;
            r_valid    <= 1'b0;
            r_id_pc    <= '0;
            r_id_pc4   <= '0;
            r_id_instr <= c_NOP_INSTR;
        end else if (!stall_i) begin
            r_pc       <= w_pc4;
            r_valid    <= 1'b1;
            r_id_pc    <= r_pc;
            r_id_pc4   <= w_pc4;
            r_id_instr <= w_fetch;
        end
    end

    assign pc_o          = r_pc;
    assign if_id_valid_o = r_valid;
    assign if_id_pc_o    = r_id_pc;
    assign if_id_pc4_o   = r_id_pc4;
    assign if_id_instr_o = r_id_instr;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Scoreboard bench for if_stage; a reference model queues the
//            expected outputs of every cycle, popped after the clock edge.
// Revision : 1.0
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] id_pc;
        logic [31:0] id_pc4;
        logic [31:0] id_instr;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_we_i;
    logic [9:0]  imem_waddr_i;
    logic [31:0] imem_wdata_i;
    logic [31:0] pc_o;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;

    int total = 0;
    int bad   = 0;

    obs_t        sb[$];
    obs_t        m;
    logic [31:0] m_mem [1024];

    if_stage #(
        .DATA_WIDTH    (32),
        .INST_MEM_DEPTH(1024),
        .RESET_PC      (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_we_i    (imem_we_i),
        .imem_waddr_i (imem_waddr_i),
        .imem_wdata_i (imem_wdata_i),
        .pc_o         (pc_o),
        .if_id_valid_o(if_id_valid_o),
        .if_id_pc_o   (if_id_pc_o),
        .if_id_pc4_o  (if_id_pc4_o),
        .if_id_instr_o(if_id_instr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t dut_obs();
        return {pc_o, if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o};
    endfunction

    // Drive one cycle, push the model's expected post-edge state, then clock.
    task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] tgt,
                       input logic we, input logic [9:0] wa, input logic [31:0] wd);
        logic [31:0] fetch;
        rst = r; stall_i = s; redirect_i = rd; redirect_pc_i = tgt;
        imem_we_i = we; imem_waddr_i = wa; imem_wdata_i = wd;
        fetch = m_mem[m.pc[11:2]];
        if (r) begin
            m = '{pc: 32'h0, valid: 1'b0, id_pc: 32'h0, id_pc4: 32'h0, id_instr: c_NOP};
        end else if (rd) begin
            m = '{pc: {tgt[31:2], 2'b00}, valid: 1'b0, id_pc: 32'h0, id_pc4: 32'h0, id_instr: c_NOP};
        end else if (!s) begin
            m = '{pc: m.pc + 32'd4, valid: 1'b1, id_pc: m.pc, id_pc4: m.pc + 32'd4, id_instr: fetch};
        end
        if (we) m_mem[wa] = wd;
        sb.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, o;
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] w;
            case (i)
                0: w = 32'h0010_0093;
                1: w = 32'h0020_0113;
                2: w = 32'h0030_0193;
                3: w = 32'h0040_0213;
                default: w = 32'hC000_0000 + 32'(i);
            endcase
            cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 10'(i), w);
            e = sb.pop_front(); o = dut_obs(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_load[%0d] got=%h exp=%h", i, o, e);
            end
        end
        total++;
        if (pc_o !== 32'h0 || if_id_valid_o !== 1'b0 || if_id_instr_o !== c_NOP ||
            if_id_pc_o !== 32'h0 || if_id_pc4_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_values got pc=%h v=%b instr=%h ipc=%h ipc4=%h exp pc=0 v=0 instr=13 ipc=0 ipc4=0",
                     pc_o, if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o);
        end
    endtask

    task automatic test_fetch();
        obs_t e, o;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
            e = sb.pop_front(); o = dut_obs(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL fetch[%0d] got=%h exp=%h", i, o, e);
            end
        end
        total++;
        if (pc_o !== 32'd8 || if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'd4 ||
            if_id_pc4_o !== 32'd8 || if_id_instr_o !== 32'h0020_0113) begin
            bad++;
            $display("FAIL fetch_second got pc=%h v=%b ipc=%h ipc4=%h instr=%h exp pc=8 v=1 ipc=4 ipc4=8 instr=00200113",
                     pc_o, if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o);
        end
    endtask

    task automatic test_stall();
        obs_t e, o;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, (i < 2), 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
            e = sb.pop_front(); o = dut_obs(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL stall[%0d] got=%h exp=%h", i, o, e);
            end
            total++;
            if (i < 2 && (pc_o !== 32'd8 || if_id_pc_o !== 32'd4 || if_id_instr_o !== 32'h0020_0113)) begin
                bad++;
                $display("FAIL stall_hold[%0d] got pc=%h ipc=%h instr=%h exp pc=8 ipc=4 instr=00200113",
                         i, pc_o, if_id_pc_o, if_id_instr_o);
            end else if (i == 2 && (pc_o !== 32'd12 || if_id_pc_o !== 32'd8 || if_id_instr_o !== 32'h0030_0193)) begin
                bad++;
                $display("FAIL stall_resume got pc=%h ipc=%h instr=%h exp pc=c ipc=8 instr=00300193",
                         pc_o, if_id_pc_o, if_id_instr_o);
            end
        end
    endtask

    task automatic test_redirect();
        obs_t e, o;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, (i == 0), 32'h40, 1'b0, 10'h0, 32'h0);
            e = sb.pop_front(); o = dut_obs(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL redirect[%0d] got=%h exp=%h", i, o, e);
            end
        end
        total++;
        if (pc_o !== 32'h44 || if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h40 || if_id_instr_o !== 32'hC000_0010) begin
            bad++;
            $display("FAIL redirect_target got pc=%h v=%b ipc=%h instr=%h exp pc=44 v=1 ipc=40 instr=c0000010",
                     pc_o, if_id_valid_o, if_id_pc_o, if_id_instr_o);
        end
    endtask

    task automatic test_redirect_stall();
        obs_t e, o;
        cyc(1'b0, 1'b1, 1'b1, 32'h23, 1'b0, 10'h0, 32'h0);
        e = sb.pop_front(); o = dut_obs(); total++;
        if (o !== e || pc_o !== 32'h20 || if_id_valid_o !== 1'b0 || if_id_instr_o !== c_NOP) begin
            bad++;
            $display("FAIL redirect_over_stall got=%h exp=%h (pc=20 bubble)", o, e);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
        e = sb.pop_front(); o = dut_obs(); total++;
        if (o !== e) begin
            bad++;
            $display("FAIL redirect_stall_next got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_wrap();
        obs_t e, o;
        logic [31:0] tg [2] = '{32'h0000_0FFC, 32'hFFFF_FFFC};
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 3; i++) begin
                cyc(1'b0, 1'b0, (i == 0), tg[t], 1'b0, 10'h0, 32'h0);
                e = sb.pop_front(); o = dut_obs(); total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL wrap[%0d][%0d] got=%h exp=%h", t, i, o, e);
                end
            end
            total++;
            if (if_id_pc_o !== tg[t] + 32'd4 || if_id_instr_o !== 32'h0010_0093) begin
                bad++;
                $display("FAIL wrap_word0[%0d] got ipc=%h instr=%h exp ipc=%h instr=00100093",
                         t, if_id_pc_o, if_id_instr_o, tg[t] + 32'd4);
            end
        end
    endtask

    task automatic test_reset_mid_and_load();
        obs_t e, o;
        cyc(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 10'h0, 32'h0);
        e = sb.pop_front(); o = dut_obs(); total++;
        if (o !== e || pc_o !== 32'h0 || if_id_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_over_redirect got=%h exp=%h", o, e);
        end
        // Fetch word 0 while overwriting it, then refetch.
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 10'h0, 32'hDEAD_BEEF);
        e = sb.pop_front(); o = dut_obs(); total++;
        if (o !== e || if_id_instr_o !== 32'h0010_0093) begin
            bad++;
            $display("FAIL load_hazard_old got=%h exp=%h", o, e);
        end
        cyc(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 10'h0, 32'h0);
        e = sb.pop_front(); o = dut_obs(); total++;
        if (o !== e) begin
            bad++;
            $display("FAIL load_hazard_redir got=%h exp=%h", o, e);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
        e = sb.pop_front(); o = dut_obs(); total++;
        if (o !== e || if_id_instr_o !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL load_hazard_new got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        for (int i = 0; i < 300; i++) begin
            logic s, rd, we, r;
            r  = ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 7) == 0);
            we = ($urandom_range(0, 2) == 0);
            cyc(r, s, rd, 32'($urandom_range(0, 8191)), we,
                10'($urandom_range(0, 31)), $urandom());
            e = sb.pop_front(); o = dut_obs(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL back_to_back[%0d] got=%h exp=%h", i, o, e);
            end
        end
    endtask

    initial begin
        m = '{pc: 32'h0, valid: 1'b0, id_pc: 32'h0, id_pc4: 32'h0, id_instr: c_NOP};
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'h0;
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        imem_we_i = 1'b0; imem_waddr_i = 10'h0; imem_wdata_i = 32'h0;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_and_load();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
